serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_serial_word_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_tx
//  Purpose  : Serialises 16-bit words onto a dClk/dDAT/dFM link, MSB first,
//             with a one-word holding register, underrun fill and a frame
//             marker on word index 0 of every FRAME_WORDS-word frame.
//  Option   : define SWTX_PARITY_EN to append an odd-parity 17th bit per word.
//  Revision : 1.0  initial release
// ============================================================================
module serial_word_tx #(
  parameter int          CLK_DIV     = 4,        // dClk half-period in clk cycles (2..255)
  parameter int          FRAME_WORDS = 32,       // words per frame (2..1024)
  parameter logic [15:0] FILL_WORD   = 16'h0000  // word sent when nothing is available
) (
  input  logic        clk,
  input  logic        reset,     // synchronous, active-low
  input  logic        enable,
  input  logic [15:0] word,
  input  logic        valid,
  output logic        ready,
  output logic        dClk,
  output logic        dDAT,
  output logic        dFM,
  output logic        busy,
  output logic        underrun
);

`ifdef SWTX_PARITY_EN
  localparam int NB    = 17;  // bits per word on the wire
  localparam int BIT_W = 5;
`else
  localparam int NB    = 16;
  localparam int BIT_W = 4;
`endif
  localparam int WIDX_W = $clog2(FRAME_WORDS);

  // Divider counts within one dClk phase, so 8 bits cover every legal CLK_DIV.
  localparam logic [7:0]        c_DIV_LAST  = 8'(CLK_DIV - 1);
  // The final high phase of a word ends one clk early; the LOAD cycle fills it.
  localparam logic [7:0]        c_DIV_END   = 8'(CLK_DIV - 2);
  localparam logic [7:0]        c_DIV_ONE   = 8'd1;
  localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(NB - 1);
  localparam logic [BIT_W-1:0]  c_BIT_ONE   = BIT_W'(1);
  localparam logic [WIDX_W-1:0] c_WIDX_LAST = WIDX_W'(FRAME_WORDS - 1);
  localparam logic [WIDX_W-1:0] c_WIDX_ONE  = WIDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                ready_q, ready_d;
  logic [NB-2:0]       sh_q, sh_d;        // bits still to send after the one on dDAT
  logic [7:0]          div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                dclk_q, dclk_d;
  logic                ddat_q, ddat_d;
  logic                dfm_q, dfm_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;

  logic [15:0]         w_src_word;
  logic                w_use_fill;
  logic [NB-1:0]       w_load_bits;

  // Pick the word for a LOAD: holding first, then a bypassed input, else fill.
  always_comb begin
    w_src_word = FILL_WORD;
    w_use_fill = 1'b1;
    if (hold_full_q) begin
      w_src_word = hold_q;
      w_use_fill = 1'b0;
    end else if (valid) begin
      w_src_word = word;
      w_use_fill = 1'b0;
    end
  end

`ifdef SWTX_PARITY_EN
  // Odd parity: the 17 transmitted bits always hold an odd number of ones.
  assign w_load_bits = {w_src_word, ~^w_src_word};
`else
  assign w_load_bits = w_src_word;
`endif

  // Next-state, holding register and serial output computation.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    div_d       = div_q;
    bit_d       = bit_q;
    widx_d      = widx_q;
    dclk_d      = dclk_q;
    ddat_d      = ddat_q;
    dfm_d       = dfm_q;
    busy_d      = busy_q;
    underrun_d  = 1'b0;

    // A LOAD drains the holding register; a bypass in LOAD does not fill it.
    if (state_q == S_LOAD) begin
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end
    end else if (valid && ready_q) begin
      hold_d      = word;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        dclk_d = 1'b0;
        ddat_d = 1'b0;
        dfm_d  = 1'b0;
        busy_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (enable) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          widx_d  = '0;
        end
      end

      S_LOAD: begin
        // dClk keeps its level here: low after IDLE, high when it closes
        // the final high phase of the previous word.
        state_d    = S_SHIFT;
        sh_d       = w_load_bits[NB-2:0];
        ddat_d     = w_load_bits[NB-1];
        dclk_d     = 1'b0;
        div_d      = '0;
        bit_d      = '0;
        dfm_d      = (widx_q == '0);
        underrun_d = w_use_fill;
      end

      S_SHIFT: begin
        if (!dclk_q) begin
          // Low phase: data is stable, far end samples on the coming rise.
          if (div_q == c_DIV_LAST) begin
            dclk_d = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + c_DIV_ONE;
          end
        end else if ((bit_q == c_BIT_LAST) && (div_q == c_DIV_END)) begin
          // End of word: enable decides between another word and IDLE.
          div_d = '0;
          if (enable) begin
            state_d = S_LOAD;
            widx_d  = (widx_q == c_WIDX_LAST) ? '0 : (widx_q + c_WIDX_ONE);
          end else begin
            state_d = S_IDLE;
            dclk_d  = 1'b0;
            ddat_d  = 1'b0;
            dfm_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end else if (div_q == c_DIV_LAST) begin
          // High->low: the only place dDAT advances within a word.
          dclk_d = 1'b0;
          div_d  = '0;
          bit_d  = bit_q + c_BIT_ONE;
          ddat_d = sh_q[NB-2];
          sh_d   = {sh_q[NB-3:0], 1'b0};
        end else begin
          div_d = div_q + c_DIV_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = ~hold_full_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      sh_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      widx_q      <= '0;
      dclk_q      <= 1'b0;
      ddat_q      <= 1'b0;
      dfm_q       <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      sh_q        <= sh_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      widx_q      <= widx_d;
      dclk_q      <= dclk_d;
      ddat_q      <= ddat_d;
      dfm_q       <= dfm_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ready    = ready_q;
  assign dClk     = dclk_q;
  assign dDAT     = ddat_q;
  assign dFM      = dfm_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_tx
//  Purpose  : Self-checking bench for serial_word_tx: a waveform-level model
//             predicts every output each cycle, a bit receiver rebuilds words.
//  Option   : honours SWTX_PARITY_EN (17-bit words) like the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_word_tx;
  localparam int          CLK_DIV     = 4;
  localparam int          FRAME_WORDS = 4;
  localparam logic [15:0] FILL_WORD   = 16'h0000;
`ifdef SWTX_PARITY_EN
  localparam int NB      = 17;
  localparam int A_EXP   = 'h14B87;  // A5C3 + parity 1
  localparam int B_EXP   = 'h00001;  // 0000 + parity 1
  localparam int E_EXP   = 'h1E1F;   // 0F0F + parity 1
  localparam int F1_EXP  = 'h00002;  // 0001 + parity 0
  localparam int F0_EXP  = 'h00001;  // 0000 + parity 1
`else
  localparam int NB      = 16;
  localparam int A_EXP   = 'h0A5C3;
  localparam int B_EXP   = 'h00000;
  localparam int E_EXP   = 'h0F0F;
  localparam int F1_EXP  = 'h00001;
  localparam int F0_EXP  = 'h00000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] word = 16'h0000;
  logic        ready, dClk, dDAT, dFM, busy, underrun;

  always #5 clk = ~clk;

  serial_word_tx #(
    .CLK_DIV     (CLK_DIV),
    .FRAME_WORDS (FRAME_WORDS),
    .FILL_WORD   (FILL_WORD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .word     (word),
    .valid    (valid),
    .ready    (ready),
    .dClk     (dClk),
    .dDAT     (dDAT),
    .dFM      (dFM),
    .busy     (busy),
    .underrun (underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [16:0] exp_word(input logic [15:0] w);
`ifdef SWTX_PARITY_EN
    return {w, ~^w};
`else
    return {1'b0, w};
`endif
  endfunction

  // ---------------- behavioural model: per-word waveform queue -------------
  logic [2:0]  wave[$];          // {dClk, dDAT, dFM} per clk of the word
  bit          m_busy = 0, m_load = 0, m_hfull = 0, chk_en = 0;
  logic [15:0] m_hdata = '0;
  int          m_widx = 0;
  logic        e_dclk = 0, e_ddat = 0, e_dfm = 0, e_busy = 0, e_und = 0, e_ready = 1;

  always @(posedge clk) begin
    logic [16:0] bits;
    logic [15:0] w;
    logic        fm;
    e_und = 1'b0;
    if (!reset) begin
      wave.delete();
      m_busy = 0; m_load = 0; m_hfull = 0; m_widx = 0;
      {e_dclk, e_ddat, e_dfm, e_busy} = 4'b0000;
      chk_en = 1;
    end else if (m_load) begin
      m_load = 0;
      if (m_hfull) begin
        w = m_hdata;
        m_hfull = 0;
      end else if (valid) begin
        w = word;
      end else begin
        w = FILL_WORD;
        e_und = 1'b1;
      end
      bits = exp_word(w);
      fm = (m_widx == 0);
      for (int b = NB - 1; b >= 0; b--) begin
        for (int k = 0; k < CLK_DIV; k++) wave.push_back({1'b0, bits[b], fm});
        for (int k = 0; k < ((b == 0) ? CLK_DIV - 1 : CLK_DIV); k++) wave.push_back({1'b1, bits[b], fm});
      end
      {e_dclk, e_ddat, e_dfm} = wave.pop_front();
      e_busy = 1'b1;
    end else begin
      if (m_busy) begin
        if (wave.size() > 0) begin
          {e_dclk, e_ddat, e_dfm} = wave.pop_front();
        end else if (enable) begin
          m_load = 1;
          e_dclk = 1'b1;
          m_widx = (m_widx + 1) % FRAME_WORDS;
        end else begin
          m_busy = 0;
          {e_dclk, e_ddat, e_dfm, e_busy} = 4'b0000;
        end
      end else if (enable) begin
        m_busy = 1; m_load = 1; m_widx = 0;
        e_busy = 1'b1;
      end
      if (valid && !m_hfull) begin
        m_hfull = 1;
        m_hdata = word;
      end
    end
    e_ready = !m_hfull;
  end

  // ---------------- compare process and bit receiver -----------------------
  int          cyc = 0, last_rise = 0, rx_cnt = 0, starts = 0;
  int          und_cnt = 0, ready_low = 0, busy_cnt = 0;
  bit          have_rise = 0, fm_and = 0;
  logic        prev_dclk = 0;
  logic [16:0] rx_sh = '0;
  logic [16:0] rxq[$];
  bit          fmq[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk1("ready", ready, e_ready);
      chk1("dClk", dClk, e_dclk);
      chk1("dDAT", dDAT, e_ddat);
      chk1("dFM", dFM, e_dfm);
      chk1("busy", busy, e_busy);
      chk1("underrun", underrun, e_und);
    end
    if (underrun) und_cnt++;
    if (!ready) ready_low++;
    if (busy) busy_cnt++;
    if (!busy) begin
      rx_cnt = 0;
      have_rise = 0;
    end else if (dClk && !prev_dclk) begin
      if (have_rise) chk("bit_period", cyc - last_rise, 2 * CLK_DIV);
      last_rise = cyc;
      have_rise = 1;
      if (rx_cnt == 0) begin
        fm_and = dFM;
        starts++;
      end else begin
        fm_and = fm_and & dFM;
      end
      rx_sh = {rx_sh[15:0], dDAT};
      rx_cnt++;
      if (rx_cnt == NB) begin
        rxq.push_back((NB == 17) ? rx_sh : {1'b0, rx_sh[15:0]});
        fmq.push_back(fm_and);
        rx_cnt = 0;
      end
    end
    prev_dclk = dClk;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk1("idle_timeout", busy, 1'b0);
  endtask

  task automatic clear();
    rxq.delete();
    fmq.delete();
    und_cnt = 0; ready_low = 0; busy_cnt = 0; starts = 0;
  endtask

  task automatic send_one(input logic [15:0] w);
    valid = 1; word = w; tick();
    valid = 0; enable = 1; tick();
    enable = 0;
    wait_idle(2000);
  endtask

  initial begin
    int          n;
    int          fed;
    logic [15:0] sent[$];
    logic [7:0]  fm_pat;

    // Reset state
    repeat (3) tick();
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_dclk", dClk, 1'b0);
    reset = 1; tick();

    // Single word from the holding register
    clear();
    send_one(16'hA5C3);
    chk("a_words", rxq.size(), 1);
    if (rxq.size() >= 1) begin
      chk("a_data", int'(rxq[0]), A_EXP);
      chk1("a_fm", fmq[0], 1'b1);
    end
    chk("a_busy_cycles", busy_cnt, NB * 2 * CLK_DIV);
    chk("a_underrun", und_cnt, 0);

    // Underrun: nothing offered for two words
    clear();
    enable = 1; n = 0;
    while (und_cnt < 2 && n < 2000) begin tick(); n++; end
    enable = 0;
    wait_idle(2000);
    chk("b_words", rxq.size(), 2);
    for (int i = 0; i < rxq.size(); i++) chk("b_data", int'(rxq[i]), B_EXP);
    chk("b_underrun", und_cnt, 2);
    chk("b_ready_low", ready_low, 0);

    // Frame of 4: stream 8 words back-to-back
    clear();
    sent.delete();
    fed = 0; n = 0; enable = 1;
    while (starts < 8 && n < 5000) begin
      if (ready && fed < 8) begin
        valid = 1; word = 16'($urandom); sent.push_back(word); fed++;
      end else begin
        valid = 0;
      end
      tick(); n++;
    end
    valid = 0; enable = 0;
    wait_idle(2000);
    chk("c_words", rxq.size(), 8);
    fm_pat = 8'b1000_1000;
    for (int i = 0; i < 8 && i < rxq.size() && i < sent.size(); i++) begin
      chk("c_data", int'(rxq[i]), int'(exp_word(sent[i])));
      chk1("c_fm", fmq[i], fm_pat[7 - i]);
    end
    chk("c_busy_cycles", busy_cnt, 8 * NB * 2 * CLK_DIV);
    chk("c_underrun", und_cnt, 0);

    // Bypass: holding empty, word offered in the LOAD cycle
    clear();
    enable = 1; tick();
    enable = 0; valid = 1; word = 16'h1234; tick();
    valid = 0;
    wait_idle(2000);
    chk("d_words", rxq.size(), 1);
    if (rxq.size() >= 1) chk("d_data", int'(rxq[0]), 'h1234 << (NB - 16));
    chk("d_underrun", und_cnt, 0);
    chk1("d_ready", ready, 1'b1);

    // Reset at bit 7 with a word waiting in holding
    clear();
    valid = 1; word = 16'hBEEF; enable = 1; tick();
    valid = 0; enable = 0; tick();
    valid = 1; word = 16'hCAFE; tick();
    valid = 0;
    n = 0;
    while (rx_cnt < 7 && n < 2000) begin tick(); n++; end
    chk1("e_ready_before", ready, 1'b0);
    reset = 0; tick();
    chk1("e_dclk", dClk, 1'b0);
    chk1("e_busy", busy, 1'b0);
    chk1("e_ready", ready, 1'b1);
    reset = 1; tick();
    clear();
    valid = 1; word = 16'h0F0F; enable = 1; tick();
    valid = 0; enable = 0;
    wait_idle(2000);
    chk("e_words", rxq.size(), 1);
    if (rxq.size() >= 1) begin
      chk("e_data", int'(rxq[0]), E_EXP);
      chk1("e_fm", fmq[0], 1'b1);
    end

    // Parity-bit words
    clear();
    send_one(16'h0001);
    send_one(16'h0000);
    chk("f_words", rxq.size(), 2);
    if (rxq.size() >= 2) begin
      chk("f_0001", int'(rxq[0]), F1_EXP);
      chk("f_0000", int'(rxq[1]), F0_EXP);
    end

    // Randomised traffic with occasional enable drops and resets
    enable = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = !enable;
      valid = ($urandom_range(0, 3) == 0);
      word  = 16'($urandom);
      reset = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset = 1; enable = 0; valid = 0;
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
